// File: rtl/brick_pkg.sv
// Shared encodings for the breakout brick field: ball direction bits, FSM states
// and the combo ceiling.
package brick_pkg;

    // ball_dir[1] selects vertical motion, ball_dir[0] horizontal motion.
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_APPLY = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic [2:0] COMBO_MAX = 3'd7;

endpackage

// File: rtl/brick_probe.sv
// Combinational neighbour lookup: turns the ball cell and direction into the
// vertical, horizontal and diagonal brick indices plus their validity.
module brick_probe
    import brick_pkg::*;
#(
    parameter int ROWS    = 7,
    parameter int COLS    = 8,
    parameter int BRICK_W = 2,
    parameter int POS_W   = 4,
    parameter int IDX_W   = 6
) (
    input  logic [POS_W-1:0] ball_row,
    input  logic [POS_W-1:0] ball_col,
    input  logic [1:0]       ball_dir,
    output logic [IDX_W-1:0] v_idx,
    output logic [IDX_W-1:0] h_idx,
    output logic [IDX_W-1:0] d_idx,
    output logic             v_ok,
    output logic             h_ok,
    output logic             d_ok
);

    int  r, c, vr, hc, own_b, h_b;
    logic row_in, col_in, own_in;

    always_comb begin
        r  = int'(ball_row);
        c  = int'(ball_col);
        vr = (ball_dir[1] == DIR_UP)   ? r - 1 : r + 1;
        hc = (ball_dir[0] == DIR_LEFT) ? c - 1 : c + 1;
        own_b = c / BRICK_W;
        h_b   = hc / BRICK_W;
        // Signed ints make a step off row/col 0 land at -1, which simply fails the range test.
        row_in = (vr >= 0) && (vr < ROWS);
        col_in = (hc >= 0) && (hc < COLS * BRICK_W);
        own_in = (c < COLS * BRICK_W);
        v_ok  = row_in && own_in;
        h_ok  = (r < ROWS) && col_in && (h_b != own_b);
        d_ok  = row_in && col_in;
        v_idx = IDX_W'(vr * COLS + own_b);
        h_idx = IDX_W'(r * COLS + h_b);
        d_idx = IDX_W'(vr * COLS + h_b);
    end

endmodule

// File: rtl/brick_field.sv
// Brick grid collision/score engine: per-brick hit points, probe/apply FSM,
// saturating score and bounce pulses. Define COMBO_EN for combo scoring.
module brick_field
    import brick_pkg::*;
#(
    parameter int ROWS    = 7,
    parameter int COLS    = 8,
    parameter int BRICK_W = 2,
    parameter int HP_W    = 2,
    parameter int INIT_HP = 1,
    parameter int SCORE_W = 10,
    parameter int POS_W   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 level_load,
    input  logic                 paddle_hit,
    input  logic [POS_W-1:0]     ball_row,
    input  logic [POS_W-1:0]     ball_col,
    input  logic [1:0]           ball_dir,
    output logic [ROWS*COLS-1:0] bricks_alive,
    output logic [SCORE_W-1:0]   score,
    output logic                 hit,
    output logic                 bounce_v,
    output logic                 bounce_h,
    output logic                 level_clear
);

    localparam int NB    = ROWS * COLS;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int SUM_W = SCORE_W + 5;
    localparam logic [HP_W-1:0]    HP_LOAD   = HP_W'(INIT_HP);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t           state;
    logic [HP_W-1:0]  hp      [NB];
    logic [HP_W-1:0]  hp_next [NB];
    logic [POS_W-1:0] lat_row, lat_col;
    logic [1:0]       lat_dir;
    logic [IDX_W-1:0] p_v_idx, p_h_idx, p_d_idx;
    logic             p_v_ok, p_h_ok, p_d_ok;
    logic [IDX_W-1:0] r_v_idx, r_h_idx, r_d_idx;
    logic             r_v_live, r_h_live, r_d_live;
    logic             v_hit, h_hit, d_hit, any_hit, any_left, dmg;
    logic [1:0]       n_dmg;
    logic [3:0]       pts;
    logic [4:0]       add;
    logic [SUM_W-1:0] sum;
    logic [SCORE_W-1:0] score_next;

    brick_probe #(
        .ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .POS_W(POS_W), .IDX_W(IDX_W)
    ) u_probe (
        .ball_row(lat_row),
        .ball_col(lat_col),
        .ball_dir(lat_dir),
        .v_idx(p_v_idx),
        .h_idx(p_h_idx),
        .d_idx(p_d_idx),
        .v_ok(p_v_ok),
        .h_ok(p_h_ok),
        .d_ok(p_d_ok)
    );

    always_comb begin
        for (int i = 0; i < NB; i++) bricks_alive[i] = (hp[i] != '0);
    end

`ifdef COMBO_EN
    logic [2:0] combo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            combo <= 3'd0;
        end else if (paddle_hit || level_load) begin
            combo <= 3'd0;
        end else if (state == ST_APPLY && any_hit && combo != COMBO_MAX) begin
            combo <= combo + 3'd1;
        end
    end

    assign pts = 4'd1 + {1'b0, combo};
`else
    logic unused_paddle;
    assign unused_paddle = paddle_hit;
    assign pts = 4'd1;
`endif

    // D only counts when neither orthogonal neighbour is live, so it can never
    // double-damage the V brick even when both map to the same index.
    always_comb begin
        v_hit   = r_v_live;
        h_hit   = r_h_live;
        d_hit   = r_d_live && !r_v_live && !r_h_live;
        any_hit = v_hit || h_hit || d_hit;
        n_dmg   = {1'b0, v_hit} + {1'b0, h_hit} + {1'b0, d_hit};
        add     = 5'(n_dmg) * 5'(pts);
        sum     = SUM_W'(score) + SUM_W'(add);
        score_next = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
        any_left = 1'b0;
        dmg      = 1'b0;
        for (int i = 0; i < NB; i++) begin
            dmg = (v_hit && r_v_idx == IDX_W'(i)) ||
                  (h_hit && r_h_idx == IDX_W'(i)) ||
                  (d_hit && r_d_idx == IDX_W'(i));
            hp_next[i] = dmg ? hp[i] - HP_W'(1) : hp[i];
            any_left   = any_left || (hp_next[i] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            for (int i = 0; i < NB; i++) hp[i] <= HP_LOAD;
            score       <= '0;
            hit         <= 1'b0;
            bounce_v    <= 1'b0;
            bounce_h    <= 1'b0;
            level_clear <= 1'b0;
            lat_row     <= '0;
            lat_col     <= '0;
            lat_dir     <= '0;
            r_v_idx     <= '0;
            r_h_idx     <= '0;
            r_d_idx     <= '0;
            r_v_live    <= 1'b0;
            r_h_live    <= 1'b0;
            r_d_live    <= 1'b0;
        end else begin
            hit      <= 1'b0;
            bounce_v <= 1'b0;
            bounce_h <= 1'b0;
            if (level_load) begin
                for (int i = 0; i < NB; i++) hp[i] <= HP_LOAD;
                level_clear <= 1'b0;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tick) begin
                            lat_row <= ball_row;
                            lat_col <= ball_col;
                            lat_dir <= ball_dir;
                            state   <= ST_PROBE;
                        end
                    end
                    ST_PROBE: begin
                        r_v_idx  <= p_v_idx;
                        r_h_idx  <= p_h_idx;
                        r_d_idx  <= p_d_idx;
                        r_v_live <= p_v_ok && bricks_alive[p_v_idx];
                        r_h_live <= p_h_ok && bricks_alive[p_h_idx];
                        r_d_live <= p_d_ok && bricks_alive[p_d_idx];
                        state    <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        hp       <= hp_next;
                        score    <= score_next;
                        hit      <= any_hit;
                        bounce_v <= v_hit || d_hit;
                        bounce_h <= h_hit || d_hit;
                        if (!any_left) begin
                            level_clear <= 1'b1;
                            state       <= ST_CLEAR;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_CLEAR: state <= ST_CLEAR;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
